// File: rtl/sd_req_arbiter.sv
// Two-client round-robin arbiter in front of a single SD host I/O block.
// One client owns the host from grant until its done pulse; a stuck host is released by a timeout.
module sd_req_arbiter #(
   parameter logic [23:0] TIMEOUT = 24'd12000000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [31:0] c0_lba,
   input  logic [31:0] c1_lba,
   input  logic        c0_rd,
   input  logic        c0_wr,
   input  logic        c1_rd,
   input  logic        c1_wr,
   output logic        c0_done,
   output logic        c1_done,
   output logic        c0_err,
   output logic        c1_err,
   input  logic [7:0]  c0_buff_din,
   input  logic [7:0]  c1_buff_din,
   output logic        c0_buff_wr,
   output logic        c1_buff_wr,
   output logic [31:0] sd_lba,
   output logic [1:0]  sd_rd,
   output logic [1:0]  sd_wr,
   input  logic        sd_ack,
   input  logic        sd_buff_wr,
   output logic [7:0]  sd_buff_din,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;

   state_t      state;
   logic        owner;
   logic        last;
   logic        op_rd;
   logic [23:0] cnt;
   logic        req0;
   logic        req1;
   logic        pick;
   logic        pick_rd;
   logic [1:0]  slot;

   assign req0      = c0_rd | c0_wr;
   assign req1      = c1_rd | c1_wr;
   // Client 1 wins when it is alone, or on a tie when client 0 was served last.
   assign pick      = req1 & (~req0 | ~last);
   assign pick_rd   = pick ? c1_rd : c0_rd;
   assign slot      = owner ? 2'b10 : 2'b01;
   assign fsm_state = state;

   always_comb begin
      c0_buff_wr  = 1'b0;
      c1_buff_wr  = 1'b0;
      sd_buff_din = c0_buff_din;
      if (state == XFER) begin
         c0_buff_wr  = ~owner & sd_buff_wr;
         c1_buff_wr  = owner & sd_buff_wr;
         sd_buff_din = owner ? c1_buff_din : c0_buff_din;
      end
   end

   // Handshake: sd_rd/sd_wr is a level request held until sd_ack is sampled high;
   // the transfer window lasts while sd_ack stays high and ends on its first low sample.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         owner   <= 1'b0;
         last    <= 1'b1;
         op_rd   <= 1'b0;
         cnt     <= 24'd0;
         sd_lba  <= 32'd0;
         sd_rd   <= 2'b00;
         sd_wr   <= 2'b00;
         c0_done <= 1'b0;
         c1_done <= 1'b0;
         c0_err  <= 1'b0;
         c1_err  <= 1'b0;
      end else begin
         c0_done <= 1'b0;
         c1_done <= 1'b0;
         c0_err  <= 1'b0;
         c1_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  owner  <= pick;
                  op_rd  <= pick_rd;
                  sd_lba <= pick ? c1_lba : c0_lba;
                  cnt    <= 24'd0;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (sd_ack) begin
                  sd_rd <= 2'b00;
                  sd_wr <= 2'b00;
                  state <= XFER;
               end else if (cnt == TIMEOUT - 24'd1) begin
                  sd_rd   <= 2'b00;
                  sd_wr   <= 2'b00;
                  c0_done <= ~owner;
                  c1_done <= owner;
                  c0_err  <= ~owner;
                  c1_err  <= owner;
                  state   <= DONE;
               end else begin
                  cnt   <= cnt + 24'd1;
                  sd_rd <= op_rd ? slot : 2'b00;
                  sd_wr <= op_rd ? 2'b00 : slot;
               end
            end
            XFER: begin
               if (!sd_ack) begin
                  c0_done <= ~owner;
                  c1_done <= owner;
                  state   <= DONE;
               end
            end
            DONE: begin
               last  <= owner;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed-plus-random bench for sd_req_arbiter against a transaction-level model of
// round-robin grant, latency, transfer window, timeout and reset behaviour.
module tb_sd_req_arbiter;

   localparam int TMO = 16;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [31:0] c0_lba, c1_lba;
   logic        c0_rd, c0_wr, c1_rd, c1_wr;
   logic        c0_done, c1_done, c0_err, c1_err;
   logic [7:0]  c0_buff_din, c1_buff_din;
   logic        c0_buff_wr, c1_buff_wr;
   logic [31:0] sd_lba;
   logic [1:0]  sd_rd, sd_wr;
   logic        sd_ack;
   logic        sd_buff_wr;
   logic [7:0]  sd_buff_din;
   logic [1:0]  fsm_state;

   int total = 0;
   int bad   = 0;
   int model_last = 1;

   sd_req_arbiter #(.TIMEOUT(24'(TMO))) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .c0_lba      (c0_lba),
      .c1_lba      (c1_lba),
      .c0_rd       (c0_rd),
      .c0_wr       (c0_wr),
      .c1_rd       (c1_rd),
      .c1_wr       (c1_wr),
      .c0_done     (c0_done),
      .c1_done     (c1_done),
      .c0_err      (c0_err),
      .c1_err      (c1_err),
      .c0_buff_din (c0_buff_din),
      .c1_buff_din (c1_buff_din),
      .c0_buff_wr  (c0_buff_wr),
      .c1_buff_wr  (c1_buff_wr),
      .sd_lba      (sd_lba),
      .sd_rd       (sd_rd),
      .sd_wr       (sd_wr),
      .sd_ack      (sd_ack),
      .sd_buff_wr  (sd_buff_wr),
      .sd_buff_din (sd_buff_din),
      .fsm_state   (fsm_state)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      @(negedge clk_sys);
   endtask

   task automatic set_req(input int c, input logic rd, input logic wr);
      if (c == 0) begin
         c0_rd = rd;
         c0_wr = wr;
      end else begin
         c1_rd = rd;
         c1_wr = wr;
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_done"}, {c0_done, c1_done}, 32'd0);
      check({tag, "_err"},  {c0_err, c1_err},   32'd0);
      check({tag, "_slot"}, {sd_rd, sd_wr},     32'd0);
   endtask

   // Start at a negedge with the DUT idle and at least one request level high.
   task automatic txn(input int d, input int h, input bit tmo, input bit keep, input bit drop_early);
      int          w;
      bit          r0, r1, rd_op;
      logic [31:0] lba;
      logic [1:0]  slot, exp_rd, exp_wr;
      r0 = c0_rd | c0_wr;
      r1 = c1_rd | c1_wr;
      if (r0 && r1) w = (model_last == 0) ? 1 : 0;
      else          w = r1 ? 1 : 0;
      rd_op  = (w == 0) ? c0_rd : c1_rd;
      lba    = (w == 0) ? c0_lba : c1_lba;
      slot   = (w == 0) ? 2'b01 : 2'b10;
      exp_rd = rd_op ? slot : 2'b00;
      exp_wr = rd_op ? 2'b00 : slot;

      step();
      check("grant_slot_quiet", {sd_rd, sd_wr}, 32'd0);
      check("grant_lba", sd_lba, lba);
      if (drop_early) set_req(w, 1'b0, 1'b0);
      step();
      check("issue_rd", sd_rd, exp_rd);
      check("issue_wr", sd_wr, exp_wr);

      if (tmo) begin
         for (int k = 3; k <= TMO; k++) begin
            step();
            check("tmo_hold_slot", {sd_rd, sd_wr}, {exp_rd, exp_wr});
            check("tmo_no_done", {c0_done, c1_done}, 32'd0);
         end
         step();
         check("tmo_slot_drop", {sd_rd, sd_wr}, 32'd0);
         check("tmo_done", {c1_done, c0_done}, slot);
         check("tmo_err", {c1_err, c0_err}, slot);
      end else begin
         for (int i = 0; i < d; i++) begin
            step();
            check("wait_slot", {sd_rd, sd_wr}, {exp_rd, exp_wr});
         end
         sd_ack = 1'b1;
         step();
         check("xfer_slot_clear", {sd_rd, sd_wr}, 32'd0);
         for (int j = 0; j < h; j++) begin
            sd_buff_wr  = 1'($urandom_range(0, 1));
            c0_buff_din = 8'($urandom);
            c1_buff_din = 8'($urandom);
            #1;
            check("buff_wr_c0", c0_buff_wr, (w == 0) && sd_buff_wr);
            check("buff_wr_c1", c1_buff_wr, (w == 1) && sd_buff_wr);
            check("buff_din", sd_buff_din, (w == 0) ? c0_buff_din : c1_buff_din);
            if (j == h - 1) sd_ack = 1'b0;
            step();
         end
         sd_buff_wr = 1'b0;
         check("done", {c1_done, c0_done}, slot);
         check("done_no_err", {c1_err, c0_err}, 32'd0);
      end

      c0_buff_din = 8'($urandom);
      c1_buff_din = ~c0_buff_din;
      #1;
      check("idle_buff_din", sd_buff_din, c0_buff_din);
      check("idle_buff_wr", {c0_buff_wr, c1_buff_wr}, 32'd0);
      check("lba_hold", sd_lba, lba);
      if (!keep) set_req(w, 1'b0, 1'b0);
      model_last = w;
      step();
      check("done_one_cycle", {c0_done, c1_done, c0_err, c1_err}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      c0_lba = 32'd0; c1_lba = 32'd0;
      c0_rd = 1'b0; c0_wr = 1'b0; c1_rd = 1'b0; c1_wr = 1'b0;
      c0_buff_din = 8'd0; c1_buff_din = 8'd0;
      sd_ack = 1'b0; sd_buff_wr = 1'b0;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check_quiet("reset");
      check("reset_lba", sd_lba, 32'd0);
      check("reset_buff_wr", {c0_buff_wr, c1_buff_wr}, 32'd0);
      reset_n = 1'b1;
      model_last = 1;
      step();

      // single read from client 0, long transfer window
      c0_lba = 32'h100;
      c0_rd  = 1'b1;
      txn(5, 512, 1'b0, 1'b0, 1'b0);

      // simultaneous read/write requests, then the loser is served
      c0_lba = 32'($urandom); c1_lba = 32'($urandom);
      c0_rd = 1'b1; c1_wr = 1'b1;
      txn(2, 4, 1'b0, 1'b0, 1'b0);
      txn(0, 3, 1'b0, 1'b0, 1'b0);

      // both keep requesting: grants alternate
      c0_rd = 1'b1; c1_wr = 1'b1;
      for (int n = 0; n < 4; n++) begin
         c0_lba = 32'($urandom); c1_lba = 32'($urandom);
         txn($urandom_range(0, 6), $urandom_range(1, 8), 1'b0, 1'b1, 1'b0);
      end
      set_req(0, 1'b0, 1'b0);
      set_req(1, 1'b0, 1'b0);
      step();

      // rd and wr both high is a read
      c1_lba = 32'($urandom);
      c1_rd = 1'b1; c1_wr = 1'b1;
      txn(1, 2, 1'b0, 1'b0, 1'b0);

      // random traffic with early request drops
      for (int n = 0; n < 10; n++) begin
         c0_lba = 32'($urandom); c1_lba = 32'($urandom);
         c0_rd = 1'($urandom_range(0, 1)); c0_wr = 1'($urandom_range(0, 1));
         c1_rd = 1'($urandom_range(0, 1)); c1_wr = 1'($urandom_range(0, 1));
         if (!(c0_rd | c0_wr | c1_rd | c1_wr)) c1_rd = 1'b1;
         txn($urandom_range(0, 10), $urandom_range(1, 12), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         set_req(0, 1'b0, 1'b0);
         set_req(1, 1'b0, 1'b0);
         step();
      end

      // host never acknowledges
      c1_lba = 32'($urandom);
      c1_rd  = 1'b1;
      txn(0, 0, 1'b1, 1'b0, 1'b0);

      // acknowledge seen while idle does nothing
      sd_ack = 1'b1;
      step();
      sd_ack = 1'b0;
      for (int n = 0; n < 4; n++) begin
         step();
         check_quiet("idle_ack");
      end
      c1_lba = 32'($urandom);
      c1_wr  = 1'b1;
      txn(3, 5, 1'b0, 1'b0, 1'b0);

      // reset in the middle of a transfer
      c0_lba = 32'($urandom);
      c0_wr  = 1'b1;
      step();
      step();
      check("rst_issue_wr", sd_wr, 32'd1);
      sd_ack = 1'b1;
      step();
      sd_buff_wr = 1'b1;
      #1;
      check("rst_xfer_buff_wr", c0_buff_wr, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check_quiet("rst_async");
      check("rst_async_lba", sd_lba, 32'd0);
      check("rst_async_buff_wr", {c0_buff_wr, c1_buff_wr}, 32'd0);
      sd_ack = 1'b0; sd_buff_wr = 1'b0; c0_wr = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      model_last = 1;
      for (int n = 0; n < 6; n++) begin
         step();
         check_quiet("rst_after");
      end

      // after reset client 0 wins a tie
      c0_lba = 32'($urandom); c1_lba = 32'($urandom);
      c0_wr = 1'b1; c1_rd = 1'b1;
      txn(1, 2, 1'b0, 1'b0, 1'b0);
      txn(1, 2, 1'b0, 1'b0, 1'b0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
